nibble_frame_packer: RTL and testbench
======================================

Name: nibble_frame_packer

Overview:
- Upstream feeder stage for the packed-array gate consumer block. Collects a serial stream of 4-bit nibbles over a valid/ready handshake.
- Assembles each group of 10 nibbles into one frame: a 16-bit word shaped [2:1][2:1][3:0] and a 24-bit word shaped [3:2][3:4][2:1][2:4], plus a 1-bit flag.
- Presents the frame on a held output register with its own valid/ready handshake.
- Aborts partial frames on input stall and counts completed and aborted frames.

Parameters:
TIMEOUT_CYCLES, 16, consecutive idle cycles inside a partial frame before abort; 0 disables timeout
CNT_W, 16, width of frame_cnt

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  nibble valid
in_ready  output  1  nibble accepted when in_valid && in_ready
in_nibble  input  4  nibble data
out_valid  output  1  frame valid
out_ready  input  1  frame consumed when out_valid && out_ready
out_odwwy  output  logic [2:1][2:1][3:0]  16-bit word
out_fzkhr  output  logic [3:2][3:4][2:1][2:4]  24-bit word
out_flag  output  bit  frame flag (see Optional Feature)
abort_pulse  output  1  one-cycle pulse on timeout abort
frame_cnt  output  CNT_W  completed frames, wraps
abort_cnt  output  8  aborted frames, saturates at 255

Behaviour:
- Reset (async assert, sync-safe deassert) values: state=COLLECT_A; nibble count=0; out_valid=0; out_odwwy, out_fzkhr and out_flag=0; abort_pulse=0; frame_cnt=0; abort_cnt=0; idle timer=0.
- FSM states: COLLECT_A, COLLECT_B, HOLD.
- in_ready=1 in COLLECT_A and COLLECT_B; in_ready=0 in HOLD.
- COLLECT_A takes nibbles n0..n3. Packing is MSB first: n0 goes to bits 15:12 (odwwy[2][2]) and n3 goes to bits 3:0. After the 4th accept the FSM moves to COLLECT_B with count=0.
- COLLECT_B takes nibbles n4..n9. n4 goes to bits 23:20 of the flattened fzkhr, where bit 23 = fzkhr[3][3][2][2]. After the 6th accept the FSM moves to HOLD.
- The output registers load on the same edge as the 10th accept. out_valid=1 from the next cycle, so latency from the last nibble accept to out_valid is 1 cycle.
- HOLD: outputs are stable while out_valid && !out_ready. On handshake: out_valid=0 next cycle, frame_cnt++, return to COLLECT_A. The next nibble can be accepted the cycle after the handshake, so there is no simultaneous HOLD/accept overlap.
- Idle timer:
  - Increments each cycle in COLLECT_B, or in COLLECT_A with count>0, when in_valid=0.
  - Clears on any accept and in HOLD.
  - When the timer reaches TIMEOUT_CYCLES (if nonzero): discard the partial frame, go to COLLECT_A with count=0, pulse abort_pulse for 1 cycle, abort_cnt++ (saturating), clear the timer.
  - The timer never runs in COLLECT_A with count=0.
- If an accept and the timeout fall in the same cycle, the accept wins: the timer clears and no abort occurs.
- frame_cnt wraps from 2^CNT_W-1 to 0.
- abort_cnt stays at 255 once saturated.
- Reset mid-frame or mid-HOLD drops all partial or pending data; no output handshake is generated.
- X/Z on in_nibble is stored as-is (4-state path); out_flag is 2-state.

Optional Feature:
- Macro: NIBBLE_FRAME_PARITY_EN.
- Defined: out_flag = XOR reduction of all 40 frame bits (odd parity), registered alongside the frame. Any X in the frame yields out_flag=0 after 2-state conversion.
- Undefined: out_flag tied to 0 and no parity logic is synthesized.

Decomposition:
- Shared package nibble_frame_pkg holds:
  - typedef odwwy_t = logic [2:1][2:1][3:0]
  - typedef fzkhr_t = logic [3:2][3:4][2:1][2:4]
  - enum state_e {COLLECT_A, COLLECT_B, HOLD}
  - localparams A_NIBBLES=4, B_NIBBLES=6
- One sub-module, nibble_idle_timer: parameterised idle counter with clear, enable and expiry output. All other logic stays in the top.

Test Plan:
1. Nibbles 1,2,3,4,5,6,7,8,9,A back-to-back, out_ready=1 -> out_odwwy=16'h1234, out_fzkhr=24'h56789A, out_valid high for exactly 1 cycle one cycle after the 10th accept, frame_cnt=1. out_flag=1 with NIBBLE_FRAME_PARITY_EN (17 ones), 0 without.
2. Same frame with out_ready=0 for 5 cycles -> in_ready=0 and outputs stable for 5 cycles; handshake on cycle 6; in_ready=1 the next cycle.
3. TIMEOUT_CYCLES=16: send 7 nibbles then idle 16 cycles -> abort_pulse one cycle, abort_cnt=1. A following full frame 0..9 packs as 16'h0123 / 24'h456789.
4. Idle exactly 15 cycles mid-frame, then resume -> no abort; frame completes correctly.
5. Assert rst_n=0 asynchronously mid-HOLD -> out_valid drops immediately, all counters return to 0, state=COLLECT_A.
6. 256 forced aborts -> abort_cnt=255 (saturated). Preload 2^CNT_W-1 frames via force, complete one more -> frame_cnt=0.

Source files
------------

// File: rtl/nibble_frame_packer_pkg.sv
// Shared types and constants for the nibble frame packer and its idle timer.
// Frame layout: 16-bit word (4 nibbles) followed by a 24-bit word (6 nibbles), MSB first.
package nibble_frame_pkg;

  typedef logic [2:1][2:1][3:0]      odwwy_t;
  typedef logic [3:2][3:4][2:1][2:4] fzkhr_t;

  typedef enum logic [1:0] {
    COLLECT_A = 2'd0,
    COLLECT_B = 2'd1,
    HOLD      = 2'd2
  } state_e;

  localparam int NIBBLE_W  = 4;
  localparam int A_NIBBLES = 4;
  localparam int B_NIBBLES = 6;
  localparam int FRAME_W   = NIBBLE_W * (A_NIBBLES + B_NIBBLES);

  // Odd parity over the whole 40-bit frame.
  function automatic logic frame_parity(input odwwy_t a, input fzkhr_t b);
    return ^{a, b};
  endfunction

endpackage

// File: rtl/nibble_frame_packer_idle_timer.sv
// Idle-cycle counter: counts enabled cycles up to LIMIT and holds there until cleared.
// LIMIT = 0 removes the counter entirely and the expiry output stays low.
module nibble_idle_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  generate
    if (LIMIT > 0) begin : g_timer
      localparam int TW = $clog2(LIMIT + 1);
      localparam logic [TW-1:0] LIMIT_V = TW'(LIMIT);

      logic [TW-1:0] r_count;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_count <= '0;
        end else if (i_clr) begin
          r_count <= '0;
        end else if (i_en && (r_count != LIMIT_V)) begin
          r_count <= r_count + 1'b1;
        end
      end

      assign o_expired = (r_count == LIMIT_V);
    end else begin : g_no_timer
      assign o_expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/nibble_frame_packer.sv
// Packs 10 serial nibbles into a 16-bit + 24-bit frame held behind a valid/ready output.
// Optional odd-parity flag over the frame is enabled by defining NIBBLE_FRAME_PARITY_EN.
module nibble_frame_packer
  import nibble_frame_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_nibble,
  output logic             out_valid,
  input  logic             out_ready,
  output odwwy_t           out_odwwy,
  output fzkhr_t           out_fzkhr,
  output bit               out_flag,
  output logic             abort_pulse,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       abort_cnt
);

  state_e           r_state;
  logic [2:0]       r_cnt;
  logic [15:0]      r_acc_a;
  logic [19:0]      r_acc_b;
  odwwy_t           r_odwwy;
  fzkhr_t           r_fzkhr;
  logic             r_out_valid;
  logic             r_abort_pulse;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [7:0]       r_abort_cnt;

  state_e           w_state_next;
  logic [2:0]       w_cnt_next;
  logic [15:0]      w_acc_a_next;
  logic [19:0]      w_acc_b_next;
  logic             w_load;
  logic             w_handshake;
  logic             w_accept;
  logic             w_timer_en;
  logic             w_timer_clr;
  logic             w_expired;
  logic             w_abort;
  fzkhr_t           w_frame_fzkhr;

  assign in_ready      = (r_state != HOLD);
  assign w_accept      = in_valid && in_ready;
  assign w_frame_fzkhr = {r_acc_b, in_nibble};

  // Timer only runs while a partial frame exists and the source is idle.
  assign w_timer_en  = !in_valid &&
                       ((r_state == COLLECT_B) || ((r_state == COLLECT_A) && (r_cnt != 3'd0)));
  assign w_timer_clr = w_accept || (r_state == HOLD) || w_abort;
  assign w_abort     = w_expired && !w_accept;

  nibble_idle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_timer_clr),
    .i_en      (w_timer_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT_A;
      r_cnt   <= 3'd0;
      r_acc_a <= '0;
      r_acc_b <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_acc_a <= w_acc_a_next;
      r_acc_b <= w_acc_b_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_acc_a_next = r_acc_a;
    w_acc_b_next = r_acc_b;
    w_load       = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      COLLECT_A: begin
        if (w_abort) begin
          w_state_next = COLLECT_A;
          w_cnt_next   = 3'd0;
        end else if (w_accept) begin
          w_acc_a_next = {r_acc_a[11:0], in_nibble};
          if (r_cnt == 3'(A_NIBBLES - 1)) begin
            w_state_next = COLLECT_B;
            w_cnt_next   = 3'd0;
          end else begin
            w_cnt_next = r_cnt + 3'd1;
          end
        end
      end
      COLLECT_B: begin
        if (w_abort) begin
          w_state_next = COLLECT_A;
          w_cnt_next   = 3'd0;
        end else if (w_accept) begin
          w_acc_b_next = {r_acc_b[15:0], in_nibble};
          if (r_cnt == 3'(B_NIBBLES - 1)) begin
            w_state_next = HOLD;
            w_cnt_next   = 3'd0;
            w_load       = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 3'd1;
          end
        end
      end
      HOLD: begin
        if (r_out_valid && out_ready) begin
          w_state_next = COLLECT_A;
          w_cnt_next   = 3'd0;
          w_handshake  = 1'b1;
        end
      end
      default: begin
        w_state_next = COLLECT_A;
        w_cnt_next   = 3'd0;
      end
    endcase
  end

  // Frame registers load on the 10th accept so out_valid rises one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_odwwy     <= '0;
      r_fzkhr     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_odwwy     <= r_acc_a;
        r_fzkhr     <= w_frame_fzkhr;
        r_out_valid <= 1'b1;
      end else if (w_handshake) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abort_pulse <= 1'b0;
      r_frame_cnt   <= '0;
      r_abort_cnt   <= 8'd0;
    end else begin
      r_abort_pulse <= w_abort;
      if (w_handshake) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_abort && (r_abort_cnt != 8'hFF)) begin
        r_abort_cnt <= r_abort_cnt + 8'd1;
      end
    end
  end

`ifdef NIBBLE_FRAME_PARITY_EN
  bit r_flag;

  // Assigning into a 2-state variable turns an X parity into 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 1'b0;
    end else if (w_load) begin
      r_flag <= frame_parity(r_acc_a, w_frame_fzkhr);
    end
  end

  assign out_flag = r_flag;
`else
  assign out_flag = 1'b0;
`endif

  assign out_valid   = r_out_valid;
  assign out_odwwy   = r_odwwy;
  assign out_fzkhr   = r_fzkhr;
  assign abort_pulse = r_abort_pulse;
  assign frame_cnt   = r_frame_cnt;
  assign abort_cnt   = r_abort_cnt;

endmodule

// File: tb/tb_nibble_frame_packer.sv
// Scoreboard bench for nibble_frame_packer: expected frames queued at send, popped at output.
module tb_nibble_frame_packer;
  import nibble_frame_pkg::*;

  localparam int TO = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_nibble = 4'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  odwwy_t        out_odwwy;
  fzkhr_t        out_fzkhr;
  bit            out_flag;
  logic          abort_pulse;
  logic [CW-1:0] frame_cnt;
  logic [7:0]    abort_cnt;

  typedef struct packed {
    logic [15:0] a;
    logic [23:0] b;
    logic        f;
  } frame_t;

  frame_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;
  int exp_frames = 0;
  int exp_aborts = 0;

  nibble_frame_packer #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_nibble   (in_nibble),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_odwwy   (out_odwwy),
    .out_fzkhr   (out_fzkhr),
    .out_flag    (out_flag),
    .abort_pulse (abort_pulse),
    .frame_cnt   (frame_cnt),
    .abort_cnt   (abort_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic exp_parity(input logic [39:0] bits);
`ifdef NIBBLE_FRAME_PARITY_EN
    return ^bits;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nibble(input logic [3:0] n);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL in_ready_before_send got %b exp 1", in_ready);
    end
    in_valid  = 1'b1;
    in_nibble = n;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_partial(input logic [39:0] bits, input int count);
    for (int i = 0; i < count; i++) send_nibble(bits[39-4*i -: 4]);
  endtask

  task automatic send_frame(input logic [39:0] bits);
    frame_t e;
    e.a = bits[39:24];
    e.b = bits[23:0];
    e.f = exp_parity(bits);
    sb_q.push_back(e);
    send_partial(bits, 10);
  endtask

  // Called right after the 10th accept; out_valid is expected immediately.
  task automatic recv_frame(input int stall);
    frame_t e;
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL out_valid_latency got %b exp 1", out_valid);
    end
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty got 0 entries exp 1");
      return;
    end
    e = sb_q.pop_front();
    for (int s = 0; s < stall; s++) begin
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_odwwy, out_fzkhr} !== {e.a, e.b}) begin
        n_err++;
        $display("FAIL hold_stable cycle %0d got v=%b rdy=%b data=%h exp v=1 rdy=0 data=%h",
                 s, out_valid, in_ready, {out_odwwy, out_fzkhr}, {e.a, e.b});
      end
      tick();
    end
    n_vec++;
    if ({out_odwwy, out_fzkhr} !== {e.a, e.b}) begin
      n_err++;
      $display("FAIL frame_data got %h_%h exp %h_%h", out_odwwy, out_fzkhr, e.a, e.b);
    end
    n_vec++;
    if (out_flag !== e.f) begin
      n_err++;
      $display("FAIL frame_flag got %b exp %b", out_flag, e.f);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_frames = (exp_frames + 1) % (1 << CW);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== CW'(exp_frames)) begin
      n_err++;
      $display("FAIL after_handshake got v=%b rdy=%b cnt=%0d exp v=0 rdy=1 cnt=%0d",
               out_valid, in_ready, frame_cnt, exp_frames);
    end
  endtask

  task automatic wait_abort();
    int c = 0;
    in_valid = 1'b0;
    while (abort_pulse !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    if (exp_aborts < 255) exp_aborts++;
    n_vec++;
    if (abort_pulse !== 1'b1 || c < TO) begin
      n_err++;
      $display("FAIL abort_pulse got pulse=%b after %0d idle cycles exp pulse=1 after >=%0d",
               abort_pulse, c, TO);
    end
    n_vec++;
    if (abort_cnt !== 8'(exp_aborts)) begin
      n_err++;
      $display("FAIL abort_cnt got %0d exp %0d", abort_cnt, exp_aborts);
    end
    tick();
    n_vec++;
    if (abort_pulse !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_pulse_width got pulse=%b rdy=%b exp pulse=0 rdy=1", abort_pulse, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || abort_pulse !== 1'b0 ||
        frame_cnt !== '0 || abort_cnt !== 8'd0 || {out_odwwy, out_fzkhr} !== 40'd0 || out_flag !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got v=%b rdy=%b ab=%b fc=%0d ac=%0d data=%h flag=%b exp all zero, rdy=1",
               out_valid, in_ready, abort_pulse, frame_cnt, abort_cnt, {out_odwwy, out_fzkhr}, out_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    send_frame(40'h123456789A);
    recv_frame(0);
  endtask

  task automatic test_hold_stall();
    send_frame(40'h123456789A);
    recv_frame(5);
  endtask

  task automatic test_timeout_abort();
    send_partial(40'hFEDCBA9876, 7);
    wait_abort();
    send_frame(40'h0123456789);
    recv_frame(0);
  endtask

  task automatic test_idle_boundary();
    send_partial(40'hA5C3E1F00F, 5);
    for (int i = 0; i < TO - 1; i++) begin
      n_vec++;
      if (abort_pulse !== 1'b0) begin
        n_err++;
        $display("FAIL idle_15_no_abort cycle %0d got pulse=1 exp 0", i);
      end
      tick();
    end
    sb_q.push_back('{a: 16'hA5C3, b: 24'hE1F00F, f: exp_parity(40'hA5C3E1F00F)});
    for (int i = 5; i < 10; i++) send_nibble(4'(40'hA5C3E1F00F >> (36 - 4*i)));
    recv_frame(1);
    // Accept lands in the cycle the timer has just reached its limit.
    send_partial(40'h13579BDF02, 3);
    for (int i = 0; i < TO; i++) tick();
    sb_q.push_back('{a: 16'h1357, b: 24'h9BDF02, f: exp_parity(40'h13579BDF02)});
    for (int i = 3; i < 10; i++) send_nibble(4'(40'h13579BDF02 >> (36 - 4*i)));
    n_vec++;
    if (abort_cnt !== 8'(exp_aborts) || abort_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL accept_beats_timeout got ac=%0d pulse=%b exp ac=%0d pulse=0",
               abort_cnt, abort_pulse, exp_aborts);
    end
    recv_frame(0);
  endtask

  task automatic test_back_to_back();
    logic [39:0] f;
    for (int k = 0; k < 4; k++) begin
      f = {$urandom(), $urandom_range(255, 0)};
      f = f[39:0];
      send_frame(f);
      recv_frame(k % 3);
    end
  endtask

  task automatic test_async_reset();
    send_frame(40'h55AA33CC0F);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || frame_cnt !== '0 || abort_cnt !== 8'd0 || in_ready !== 1'b1 ||
        dut.r_state !== COLLECT_A || {out_odwwy, out_fzkhr} !== 40'd0) begin
      n_err++;
      $display("FAIL async_reset got v=%b fc=%0d ac=%0d rdy=%b st=%0d data=%h exp v=0 fc=0 ac=0 rdy=1 st=0 data=0",
               out_valid, frame_cnt, abort_cnt, in_ready, dut.r_state, {out_odwwy, out_fzkhr});
    end
    sb_q.delete();
    exp_frames = 0;
    exp_aborts = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_idle got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_abort_saturate();
    for (int i = 0; i < 257; i++) begin
      send_nibble(4'(i));
      wait_abort();
    end
  endtask

  task automatic test_frame_cnt_wrap();
    logic [39:0] f;
    for (int k = 0; k < (1 << CW); k++) begin
      f = {8'(k), 32'(k * 32'h9E3779B1)};
      send_frame(f);
      recv_frame(0);
    end
    n_vec++;
    if (frame_cnt !== '0) begin
      n_err++;
      $display("FAIL frame_cnt_wrap got %0d exp 0", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_stall();
    test_timeout_abort();
    test_idle_boundary();
    test_back_to_back();
    test_async_reset();
    test_abort_saturate();
    test_frame_cnt_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
